// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and writeback encodings plus the control-word
// bundle passed from control_decode to the control_unit register.
package ctrl_pkg;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_ITYPE = 3'd1;
    localparam logic [2:0] OP_LW    = 3'd2;
    localparam logic [2:0] OP_SW    = 3'd3;
    localparam logic [2:0] OP_BR0   = 3'd4;
    localparam logic [2:0] OP_BR1   = 3'd5;
    localparam logic [2:0] OP_JIN   = 3'd6;
    localparam logic [2:0] OP_JOUT  = 3'd7;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [2:0] WB_MEM  = 3'd0;
    localparam logic [2:0] WB_ALU  = 3'd1;
    localparam logic [2:0] WB_LINK = 3'd2;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [2:0] reg_store;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump_out;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/func to control-word decoder.
// CTRL_ILLEGAL_FUNC_NOP_EN turns unknown R/I-type funcs into a full NOP.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [3:0] func,
    output ctrl_t      ctrl
);

    logic [2:0] r_alu_op;
    logic [2:0] i_alu_op;
    logic       func_legal;

    assign func_legal = (func[3:2] == 2'b00);

    always_comb begin
        r_alu_op = ALU_NOP;
        unique case (func)
            4'd0:    r_alu_op = ALU_ADD;
            4'd1:    r_alu_op = ALU_SUB;
            4'd2:    r_alu_op = ALU_OR;
            4'd3:    r_alu_op = ALU_AND;
            default: r_alu_op = ALU_NOP;
        endcase
    end

    always_comb begin
        i_alu_op = ALU_NOP;
        unique case (func)
            4'd0:    i_alu_op = ALU_ADD;
            4'd1:    i_alu_op = ALU_SLL;
            4'd2:    i_alu_op = ALU_SRL;
            4'd3:    i_alu_op = ALU_XOR;
            default: i_alu_op = ALU_NOP;
        endcase
    end

    always_comb begin
        ctrl = CTRL_NOP;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_store = WB_ALU;
                ctrl.alu_op    = r_alu_op;
            end
            OP_ITYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b0;
                ctrl.reg_store = WB_ALU;
                ctrl.alu_op    = i_alu_op;
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_store = WB_MEM;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BR0, OP_BR1: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_JIN: begin
                ctrl.branch    = 1'b1;
                ctrl.reg_store = WB_LINK;
            end
            OP_JOUT: begin
                ctrl.branch   = 1'b1;
                ctrl.jump_out = 1'b1;
            end
            default: ctrl = CTRL_NOP;
        endcase
`ifdef CTRL_ILLEGAL_FUNC_NOP_EN
        // Unknown arithmetic funcs must not write the register file.
        if ((opcode == OP_RTYPE || opcode == OP_ITYPE) && !func_legal) begin
            ctrl = CTRL_NOP;
        end
`endif
    end

`ifndef CTRL_ILLEGAL_FUNC_NOP_EN
    logic unused_func_legal;
    assign unused_func_legal = func_legal;
`endif

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: registers the decoded control word, 1-cycle latency.
// Optional macro CTRL_ILLEGAL_FUNC_NOP_EN (see control_decode).
module control_unit
    import ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [3:0] func,
    output logic       RegWrite,
    output logic       ALUsrc,
    output logic [2:0] ALUop,
    output logic [2:0] RegStore,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       Branch,
    output logic       JumpOut
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegWrite = ctrl_q.reg_write;
    assign ALUsrc   = ctrl_q.alu_src;
    assign ALUop    = ctrl_q.alu_op;
    assign RegStore = ctrl_q.reg_store;
    assign MemWrite = ctrl_q.mem_write;
    assign MemRead  = ctrl_q.mem_read;
    assign Branch   = ctrl_q.branch;
    assign JumpOut  = ctrl_q.jump_out;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: decode-table model compared
// every negedge, plus hand-computed literal vectors.
module tb_control_unit;

    logic       CLK;
    logic       reset;
    logic [2:0] opcode;
    logic [3:0] func;
    logic       RegWrite;
    logic       ALUsrc;
    logic [2:0] ALUop;
    logic [2:0] RegStore;
    logic       MemWrite;
    logic       MemRead;
    logic       Branch;
    logic       JumpOut;

    int checks;
    int errors;
    bit cmp_en;

    logic [11:0] exp_q;
    logic [11:0] dut_w;

    control_unit dut (
        .CLK      (CLK),
        .reset    (reset),
        .opcode   (opcode),
        .func     (func),
        .RegWrite (RegWrite),
        .ALUsrc   (ALUsrc),
        .ALUop    (ALUop),
        .RegStore (RegStore),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Branch   (Branch),
        .JumpOut  (JumpOut)
    );

    // {RegWrite,ALUsrc,ALUop,RegStore,MemWrite,MemRead,Branch,JumpOut}
    assign dut_w = {RegWrite, ALUsrc, ALUop, RegStore,
                    MemWrite, MemRead, Branch, JumpOut};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] model(input int op, input int fn);
        int rw, src, aop, rs, mw, mr, br, jo;
        rw = 0; src = 0; aop = 0; rs = 0;
        mw = 0; mr = 0; br = 0; jo = 0;
        if (op == 0 || op == 1) begin
            rw  = 1;
            rs  = 1;
            src = (op == 0) ? 1 : 0;
            if (fn < 4)
                aop = (op == 0) ? fn + 1 : ((fn == 0) ? 1 : fn + 4);
`ifdef CTRL_ILLEGAL_FUNC_NOP_EN
            if (fn >= 4) begin
                rw = 0; rs = 0; src = 0;
            end
`endif
        end else if (op == 2) begin
            rw = 1; mr = 1; aop = 1;
        end else if (op == 3) begin
            mw = 1; aop = 1;
        end else if (op == 4 || op == 5) begin
            br = 1; aop = 2;
        end else if (op == 6) begin
            br = 1; rs = 2;
        end else begin
            br = 1; jo = 1;
        end
        return {rw[0], src[0], aop[2:0], rs[2:0],
                mw[0], mr[0], br[0], jo[0]};
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) exp_q <= '0;
        else        exp_q <= model(int'(opcode), int'(func));
    end

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model", dut_w, exp_q);
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL memrw_excl: got MemRead=1 MemWrite=1, expected not both");
            end
            checks++;
            if (Branch && RegWrite) begin
                errors++;
                $display("FAIL branch_rw: got Branch=1 RegWrite=1, expected not both");
            end
        end
    end

    task automatic step(input logic [2:0] op, input logic [3:0] fn,
                        input logic [11:0] want, input string name);
        opcode = op;
        func   = fn;
        @(posedge CLK);
        #1;
        check(name, dut_w, want);
        #1;
    endtask

    logic [11:0] nop_exp;

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 0;
        reset  = 1'b0;
        opcode = 3'd0;
        func   = 4'd0;
`ifdef CTRL_ILLEGAL_FUNC_NOP_EN
        nop_exp = 12'b0_0_000_000_0000;
`else
        nop_exp = 12'b1_1_000_001_0000;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check("reset_zero", dut_w, 12'b0);
        cmp_en = 1;
        @(negedge CLK);
        #1;
        reset = 1'b1;

        step(3'd0, 4'd0, 12'b1_1_001_001_0000, "r_add");
        step(3'd0, 4'd1, 12'b1_1_010_001_0000, "r_sub");
        step(3'd0, 4'd2, 12'b1_1_011_001_0000, "r_or");
        step(3'd0, 4'd3, 12'b1_1_100_001_0000, "r_and");
        step(3'd1, 4'd0, 12'b1_0_001_001_0000, "i_add");
        step(3'd1, 4'd1, 12'b1_0_101_001_0000, "i_sll");
        step(3'd1, 4'd2, 12'b1_0_110_001_0000, "i_srl");
        step(3'd1, 4'd3, 12'b1_0_111_001_0000, "i_xor");
        step(3'd2, 4'd7, 12'b1_0_001_000_0100, "lw");
        step(3'd3, 4'd5, 12'b0_0_001_000_1000, "sw");
        step(3'd4, 4'd0, 12'b0_0_010_000_0010, "br0");
        step(3'd5, 4'hf, 12'b0_0_010_000_0010, "br1");
        step(3'd6, 4'd1, 12'b0_0_000_010_0010, "jin");
        step(3'd7, 4'd2, 12'b0_0_000_000_0011, "jout");
        step(3'd0, 4'd9, nop_exp, "r_func9");
        step(3'd1, 4'd15, {nop_exp[11], 1'b0, nop_exp[9:0]}, "i_func15");

        // latency: change to SW just after the LW edge
        step(3'd2, 4'd0, 12'b1_0_001_000_0100, "lat_lw");
        opcode = 3'd3;
        #3;
        check("lat_hold", dut_w, 12'b1_0_001_000_0100);
        @(posedge CLK);
        #1;
        check("lat_sw", dut_w, 12'b0_0_001_000_1000);

        // async reset mid-cycle with jump-out loaded
        step(3'd7, 4'd0, 12'b0_0_000_000_0011, "pre_rst_jout");
        #1;
        reset = 1'b0;
        #1;
        check("async_rst", dut_w, 12'b0);
        @(negedge CLK);
        #1;
        opcode = 3'd0;
        func   = 4'd2;
        reset  = 1'b1;
        #1;
        check("rst_rel_hold", dut_w, 12'b0);
        @(posedge CLK);
        #1;
        check("rst_rel_load", dut_w, 12'b1_1_011_001_0000);

        for (int i = 0; i < 16; i++) begin
            opcode = 3'($urandom_range(0, 7));
            func   = 4'($urandom_range(0, 15));
            @(posedge CLK);
            #2;
        end
        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
